acc_cpu_core: RTL and testbench



---
 rtl/acc_cpu_pkg.sv | 32 +++
 rtl/acc_cpu_imem.sv | 19 +
 rtl/acc_cpu_core.sv | 112 +++++++++++
 tb/tb_acc_cpu_core.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_cpu_pkg.sv
// acc_cpu_pkg: instruction field layout, opcode constants and FSM states for acc_cpu_core.
package acc_cpu_pkg;
   localparam int SRC_LSB  = 0;
   localparam int OP_LSB   = 3;
   localparam int DST_LSB  = 6;
   localparam int FLOW_BIT = 9;
   localparam int JUMP_LSB = 10;
   localparam int FIELD_W  = 3;

   localparam logic [2:0] SRC_ZERO = 3'd0;
   localparam logic [2:0] SRC_ONE  = 3'd1;
   localparam logic [2:0] SRC_ACC  = 3'd2;
   localparam logic [2:0] SRC_BAK  = 3'd3;
   localparam logic [2:0] SRC_IN   = 3'd4;
   localparam logic [2:0] SRC_JUMP = 3'd5;

   localparam logic [2:0] OP_PASS = 3'd0;
   localparam logic [2:0] OP_ADD  = 3'd1;
   localparam logic [2:0] OP_SUB  = 3'd2;
   localparam logic [2:0] OP_SWP  = 3'd3;
   localparam logic [2:0] OP_SAV  = 3'd4;
   localparam logic [2:0] OP_NEG  = 3'd5;
   localparam logic [2:0] OP_NOP  = 3'd6;
   localparam logic [2:0] OP_HALT = 3'd7;

   localparam logic [2:0] DST_NONE = 3'd0;
   localparam logic [2:0] DST_ACC  = 3'd1;
   localparam logic [2:0] DST_BAK  = 3'd2;
   localparam logic [2:0] DST_OUT  = 3'd3;

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_WAIT_OUT, S_HALT} state_t;
endpackage

// File: rtl/acc_cpu_imem.sv
// acc_cpu_imem: single-port synchronous program RAM with registered read data, contents not reset.
module acc_cpu_imem #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 14
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
   end
endmodule

// File: rtl/acc_cpu_core.sv
// acc_cpu_core: accumulator CPU with private program RAM, acc/bak registers,
// conditional jumps, halt and ready/valid input and output streams.
module acc_cpu_core import acc_cpu_pkg::*; #(
   parameter  int DATA_W = 8,
   parameter  int PC_W   = 4,
   localparam int INSN_W = 10 + PC_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              prog_we,
   input  logic [PC_W-1:0]   prog_addr,
   input  logic [INSN_W-1:0] prog_wdata,
   input  logic              start,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              halted,
   output logic [PC_W-1:0]   pc_o,
   output logic [DATA_W-1:0] acc_o
);
   state_t state, state_nx;
   logic [PC_W-1:0] pc, jump;
   logic [DATA_W-1:0] acc, bak, src_val, result;
   logic [INSN_W-1:0] insn;
   logic [2:0] src, op, dst;
   logic flow, idle, stall, fire, wb_alu, wb_out;

   // The RAM port is shared: loads only happen while idle, fetches only while running.
   acc_cpu_imem #(.ADDR_W(PC_W), .DATA_W(INSN_W)) u_imem (
      .clk   (clk),
      .we    (prog_we && idle),
      .re    (state == S_FETCH),
      .addr  (idle ? prog_addr : pc),
      .wdata (prog_wdata),
      .rdata (insn)
   );

   assign src  = insn[SRC_LSB +: FIELD_W];
   assign op   = insn[OP_LSB +: FIELD_W];
   assign dst  = insn[DST_LSB +: FIELD_W];
   assign flow = insn[FLOW_BIT];
   assign jump = insn[JUMP_LSB +: PC_W];

   assign idle     = state == S_IDLE || state == S_HALT;
   assign in_ready = state == S_EXEC && src == SRC_IN;
   assign stall    = in_ready && !in_valid;
   assign fire     = state == S_EXEC && !stall;
   // SWP, SAV, NOP and HALT bypass the dst field entirely, including the output stream.
   assign wb_alu   = op inside {OP_PASS, OP_ADD, OP_SUB, OP_NEG};
   assign wb_out   = wb_alu && dst == DST_OUT;

   assign busy   = !idle;
   assign halted = state == S_HALT;
   assign pc_o   = pc;
   assign acc_o  = acc;

   always_comb begin
      src_val = src == SRC_ONE  ? DATA_W'(1) :
                src == SRC_ACC  ? acc :
                src == SRC_BAK  ? bak :
                src == SRC_IN   ? in_data :
                src == SRC_JUMP ? DATA_W'(jump) : '0;
      result  = op == OP_ADD ? acc + src_val :
                op == OP_SUB ? acc - src_val :
                op == OP_SWP ? bak :
                op == OP_SAV ? acc :
                op == OP_NEG ? '0 - src_val : src_val;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE, S_HALT: if (start) state_nx = S_FETCH;
         S_FETCH:        state_nx = S_EXEC;
         S_EXEC:         if (!stall) state_nx = wb_out ? S_WAIT_OUT : op == OP_HALT ? S_HALT : S_FETCH;
         S_WAIT_OUT:     if (out_ready) state_nx = S_FETCH;
         default:        state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         pc        <= '0;
         acc       <= '0;
         bak       <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         state <= state_nx;
         if (idle && start) pc <= '0;
         if (fire && op != OP_HALT) pc <= (flow && result == '0) ? jump : pc + 1'b1;
         if (fire && op == OP_SWP) begin
            acc <= bak;
            bak <= acc;
         end
         if (fire && op == OP_SAV) bak <= acc;
         if (fire && wb_alu && dst == DST_ACC) acc <= result;
         if (fire && wb_alu && dst == DST_BAK) bak <= result;
         if (fire && wb_out) begin
            out_data  <= result;
            out_valid <= 1'b1;
         end else if (state == S_WAIT_OUT && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_acc_cpu_core.sv
// tb_acc_cpu_core: table-driven directed programs, hand sequences for wrap/reset,
// and random forward-jumping programs checked against an ISA-level interpreter.
module tb_acc_cpu_core;
   localparam int IW = 14;
   typedef logic [15:0][IW-1:0] prog_t;
   typedef struct {
      prog_t prog; logic [7:0] in0; int iv_hold; int ordy_hold;
      logic [7:0] acc; int pc; int nout; logic [7:0] last; int busy; int irdy; int ovc;
   } vec_t;

   logic clk = 1'b0, rst = 1'b1, prog_we = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic in_ready, out_valid, busy, halted;
   logic [3:0] prog_addr = '0, pc_o;
   logic [IW-1:0] prog_wdata = '0;
   logic [7:0] in_data = '0, out_data, acc_o;

   int tests = 0, fails = 0;
   logic [7:0] in_q[$], outs[$], exp_outs[$];
   int in_idx, ov_cycles, ir_cycles, busy_cycles, hold_err;
   logic prev_ov, prev_hs;
   logic [7:0] prev_od;
   logic [3:0] prev_pc;
   logic [7:0] m_acc;
   int m_pc, m_in;
   bit m_halt;

   always #5 clk = ~clk;

   acc_cpu_core dut (
      .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
      .start(start), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .halted(halted), .pc_o(pc_o), .acc_o(acc_o)
   );

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic prog_t pg(input logic [IW-1:0] w0, w1, w2, w3, w4, w5);
      prog_t p;
      for (int i = 0; i < 16; i++) p[i] = 14'h038;
      p[0] = w0; p[1] = w1; p[2] = w2; p[3] = w3; p[4] = w4; p[5] = w5;
      return p;
   endfunction

   task automatic do_reset();
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic load(input prog_t p);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         prog_we = 1'b1; prog_addr = 4'(i); prog_wdata = p[i];
      end
      @(negedge clk) prog_we = 1'b0;
   endtask

   task automatic clear_stats();
      in_idx = 0; outs.delete();
      ov_cycles = 0; ir_cycles = 0; busy_cycles = 0; hold_err = 0;
      prev_ov = 1'b0; prev_hs = 1'b0; prev_od = '0; prev_pc = '0;
   endtask

   task automatic tick(input bit st, input bit iv, input bit ordy);
      @(negedge clk);
      start = st; in_valid = iv; out_ready = ordy;
      in_data = (in_idx < in_q.size()) ? in_q[in_idx] : 8'h00;
      #1;
      if (prev_ov && !prev_hs && (!out_valid || out_data != prev_od || pc_o != prev_pc)) hold_err++;
      ov_cycles += int'(out_valid); ir_cycles += int'(in_ready); busy_cycles += int'(busy);
      if (in_valid && in_ready) in_idx++;
      if (out_valid && out_ready) outs.push_back(out_data);
      prev_ov = out_valid; prev_hs = out_valid && out_ready; prev_od = out_data; prev_pc = pc_o;
   endtask

   task automatic run(input int iv_hold, input int ordy_hold, input bit rnd, output bit done);
      done = 1'b0;
      tick(1'b1, 1'b0, 1'b1);
      for (int k = 1; k < 400 && !done; k++) begin
         tick(1'b0, rnd ? 1'($urandom % 2) : (k > iv_hold), rnd ? 1'($urandom % 2) : (k > ordy_hold));
         done = halted;
      end
   endtask

   // Instruction-set interpreter: one loop iteration per instruction.
   task automatic model(input prog_t p);
      logic [7:0] a, b, v, r, t;
      logic [13:0] w;
      int pc, k;
      a = 0; b = 0; pc = 0; k = 0; m_halt = 0; exp_outs.delete();
      for (int n = 0; n < 64 && !m_halt; n++) begin
         w = p[pc];
         case (w[2:0])
            3'd1: v = 8'd1;
            3'd2: v = a;
            3'd3: v = b;
            3'd4: begin v = in_q[k]; k++; end
            3'd5: v = {4'd0, w[13:10]};
            default: v = 8'd0;
         endcase
         r = v;
         case (w[5:3])
            3'd1: r = a + v;
            3'd2: r = a - v;
            3'd3: begin t = a; a = b; b = t; r = a; end
            3'd4: begin b = a; r = a; end
            3'd5: r = 8'd0 - v;
            3'd7: m_halt = 1;
            default: ;
         endcase
         if (w[5:3] inside {3'd0, 3'd1, 3'd2, 3'd5}) begin
            if (w[8:6] == 3'd1) a = r;
            if (w[8:6] == 3'd2) b = r;
            if (w[8:6] == 3'd3) exp_outs.push_back(r);
         end
         if (!m_halt) pc = (w[9] && r == 0) ? int'(w[13:10]) : (pc + 1) % 16;
      end
      m_acc = a; m_pc = pc; m_in = k;
   endtask

   initial begin
      vec_t vt[5];
      bit done, wrap, all_busy;
      logic [3:0] lp;
      prog_t p;
      int jf;

      vt[0] = '{pg(14'h041, 14'h04A, 14'h04A, 14'h0C2, 14'h038, 14'h038), 8'h00, 0, 0, 8'd4, 4, 1, 8'd4, 11, 0, 1};
      vt[1] = '{pg(14'hC45, 14'hE51, 14'h600, 14'h038, 14'h038, 14'h038), 8'h00, 0, 0, 8'd0, 3, 0, 8'd0, 14, 0, 0};
      vt[2] = '{pg(14'h1C45, 14'h020, 14'h069, 14'h018, 14'h0CB, 14'h038), 8'h00, 0, 0, 8'd7, 5, 1, 8'd6, 13, 0, 1};
      vt[3] = '{pg(14'h044, 14'h038, 14'h038, 14'h038, 14'h038, 14'h038), 8'hA5, 6, 0, 8'hA5, 1, 0, 8'd0, 9, 6, 0};
      vt[4] = '{pg(14'h1C45, 14'h0C2, 14'h038, 14'h038, 14'h038, 14'h038), 8'h00, 0, 8, 8'd7, 2, 1, 8'd7, 11, 0, 5};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_busy", busy, 0); chk("reset_halted", halted, 0); chk("reset_in_ready", in_ready, 0);
      chk("reset_out_valid", out_valid, 0); chk("reset_out_data", out_data, 0);
      chk("reset_pc", pc_o, 0); chk("reset_acc", acc_o, 0);

      for (int i = 0; i < 5; i++) begin
         do_reset();
         load(vt[i].prog);
         in_q.delete(); in_q.push_back(vt[i].in0);
         clear_stats();
         run(vt[i].iv_hold, vt[i].ordy_hold, 1'b0, done);
         chk($sformatf("v%0d_halted", i), int'(done), 1);
         chk($sformatf("v%0d_acc", i), acc_o, vt[i].acc);
         chk($sformatf("v%0d_pc", i), pc_o, vt[i].pc);
         chk($sformatf("v%0d_nout", i), outs.size(), vt[i].nout);
         if (vt[i].nout > 0 && outs.size() > 0) chk($sformatf("v%0d_out", i), outs[outs.size()-1], vt[i].last);
         chk($sformatf("v%0d_busy_cycles", i), busy_cycles, vt[i].busy);
         chk($sformatf("v%0d_in_ready_cycles", i), ir_cycles, vt[i].irdy);
         chk($sformatf("v%0d_out_valid_cycles", i), ov_cycles, vt[i].ovc);
         chk($sformatf("v%0d_hold", i), hold_err, 0);
      end

      // NOP loop: pc wraps, core never leaves busy, loads are ignored while running.
      do_reset();
      for (int i = 0; i < 16; i++) p[i] = 14'h030;
      load(p);
      clear_stats();
      tick(1'b1, 1'b0, 1'b1);
      wrap = 0; all_busy = 1; lp = pc_o;
      for (int k = 1; k < 90; k++) begin
         if (k == 10) begin prog_we = 1'b1; prog_addr = 4'd5; prog_wdata = 14'h038; end
         if (k == 14) prog_we = 1'b0;
         tick(1'b0, 1'b0, 1'b1);
         if (!busy) all_busy = 0;
         if (lp == 4'd15 && pc_o == 4'd0) wrap = 1;
         lp = pc_o;
      end
      chk("nop_wrap", int'(wrap), 1);
      chk("nop_busy", int'(all_busy), 1);
      chk("nop_write_ignored", halted, 0);

      // Reset while waiting on output backpressure.
      do_reset();
      load(pg(14'h1C45, 14'h0C2, 14'h038, 14'h038, 14'h038, 14'h038));
      in_q.delete();
      clear_stats();
      tick(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 20 && !out_valid; k++) tick(1'b0, 1'b0, 1'b0);
      chk("wo_reached", out_valid, 1);
      rst = 1'b1;
      #1;
      chk("wo_async_out_valid", out_valid, 0);
      chk("wo_async_busy", busy, 0);
      chk("wo_async_acc", acc_o, 0);
      @(negedge clk) rst = 1'b0;
      #1;
      chk("wo_idle_pc", pc_o, 0);
      clear_stats();
      run(0, 0, 1'b0, done);
      chk("wo_rerun_halted", int'(done), 1);
      chk("wo_rerun_acc", acc_o, 7);
      chk("wo_rerun_nout", outs.size(), 1);
      if (outs.size() > 0) chk("wo_rerun_out", outs[0], 7);

      // Random programs whose jumps only go forward, so each one halts within 16 instructions.
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < 15; i++) begin
            logic [2:0] op;
            op = 3'($urandom % 8);
            if (op == 3'd7 && $urandom % 4 != 0) op = 3'd6;
            jf = i + 1 + int'($urandom % (15 - i));
            p[i] = {4'(jf), 1'($urandom % 2), 3'($urandom % 8), op, 3'($urandom % 8)};
         end
         p[15] = 14'h038;
         in_q.delete();
         for (int i = 0; i < 16; i++) in_q.push_back(8'($urandom));
         model(p);
         do_reset();
         load(p);
         clear_stats();
         run(0, 0, 1'b1, done);
         chk($sformatf("r%0d_halted", n), int'(done), int'(m_halt));
         chk($sformatf("r%0d_acc", n), acc_o, m_acc);
         chk($sformatf("r%0d_pc", n), pc_o, m_pc);
         chk($sformatf("r%0d_inputs", n), in_idx, m_in);
         chk($sformatf("r%0d_nout", n), outs.size(), exp_outs.size());
         for (int i = 0; i < outs.size() && i < exp_outs.size(); i++)
            chk($sformatf("r%0d_out%0d", n, i), outs[i], exp_outs[i]);
         chk($sformatf("r%0d_hold", n), hold_err, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
